adc_channel_monitor: RTL and testbench

Parametrised multi-channel successor to the single-channel ADC readout path. It sits between the ADC sequencer response stream and the HEX display drivers, clocked on the 50 MHz system clock. It captures samples per channel and measures the cycle count between consecutive samples of each channel. For one selectable channel it converts the sample to millivolts, using a sequential divider and a sequential binary-to-BCD converter, and presents ready-to-display decimal digits.

---
 rtl/adc_channel_monitor.sv | 274 +++++++++++++++++++++++++++
 tb/tb_adc_channel_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_channel_monitor.sv
`timescale 1ns/1ps
// adc_channel_monitor
//
// Multi-channel ADC readout monitor between the ADC sequencer response stream
// and the HEX display drivers.
//
// What it does:
//   - Captures each accepted sample.
//   - Measures the cycle distance between consecutive samples of each channel.
//   - For the selected display channel, converts the sample to millivolts with
//     a sequential restoring divider, then to packed BCD with a sequential
//     double-dabble.
//
// Ports:
//   MAX10_CLK1_50     system clock, all logic on its rising edge
//   reset             synchronous, active-high
//   response_valid    ADC sample beat
//   response_channel  ADC channel number of the beat
//   response_data     raw sample
//   display_channel   local index of the channel to convert
//   sample_valid      pulse: sample_channel/sample_data updated
//   sample_channel    local index of the last accepted sample
//   sample_data       last accepted sample
//   period_valid      pulse: period_cycles updated
//   period_cycles     cycles between the last two samples of sample_channel
//   mv_bcd            millivolts, packed BCD, most significant digit on top
//   bcd_channel       channel that mv_bcd belongs to
//   bcd_valid         pulse: mv_bcd/bcd_channel updated
//   busy              converter not idle
//   drop_count        saturating count of overwritten conversion requests
module adc_channel_monitor #(
  parameter int DATA_W   = 12,
  parameter int NUM_CH   = 2,
  parameter int CH_BASE  = 1,
  parameter int CH_W     = 5,
  parameter int VREF_MV  = 5000,
  parameter int PERIOD_W = 16,
  parameter int DIGITS   = 4,
  localparam int MV_W    = $clog2(VREF_MV + 1),
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  reset,
  input  logic                  response_valid,
  input  logic [CH_W-1:0]       response_channel,
  input  logic [DATA_W-1:0]     response_data,
  input  logic [IDX_W-1:0]      display_channel,
  output logic                  sample_valid,
  output logic [IDX_W-1:0]      sample_channel,
  output logic [DATA_W-1:0]     sample_data,
  output logic                  period_valid,
  output logic [PERIOD_W-1:0]   period_cycles,
  output logic [4*DIGITS-1:0]   mv_bcd,
  output logic [IDX_W-1:0]      bcd_channel,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic [7:0]            drop_count
);

  localparam int PROD_W = DATA_W + MV_W;
  localparam int STEP_W = $clog2(MV_W + 1);
  localparam logic [DATA_W:0]     DIVISOR    = (DATA_W + 1)'((1 << DATA_W) - 1);
  localparam logic [STEP_W-1:0]   LAST_STEP  = STEP_W'(MV_W - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  typedef enum logic [1:0] {IDLE, DIV, BCD, DONE} conv_state_t;

  conv_state_t state, state_next;

  logic [CH_W-1:0]   ch_offset;
  logic              beat_accept;
  logic [IDX_W-1:0]  beat_idx;
  logic              sample_match;

  logic [PERIOD_W-1:0] period_cnt [NUM_CH];
  logic [NUM_CH-1:0]   ch_seen;

  logic              conv_req;
  logic              conv_start;
  logic [DATA_W-1:0] start_data;
  logic [IDX_W-1:0]  start_ch;
  logic [PROD_W-1:0] start_product;

  logic              pend_full;
  logic [DATA_W-1:0] pend_data;
  logic [IDX_W-1:0]  pend_ch;

  logic [DATA_W-1:0] div_rem;
  logic [MV_W-1:0]   div_q;
  logic [DATA_W:0]   div_trial;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem_next;
  logic [4*DIGITS-1:0] bcd_acc;
  logic [STEP_W-1:0] step_cnt;
  logic              step_last;
  logic [IDX_W-1:0]  conv_ch;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the
  // next binary bit. The top bit of the adjusted value is always 0 because
  // the result fits in DIGITS digits.
  function automatic logic [4*DIGITS-1:0] dabble_step(
    input logic [4*DIGITS-1:0] acc,
    input logic                in_bit
  );
    logic [4*DIGITS-1:0] adj;
    adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    return {adj[4*DIGITS-2:0], in_bit};
  endfunction

  // Channel window check via an offset. This avoids overflow of
  // CH_BASE+NUM_CH in the channel field width.
  assign ch_offset   = response_channel - CH_W'(CH_BASE);
  assign beat_accept = response_valid && (response_channel >= CH_W'(CH_BASE)) &&
                       (ch_offset < CH_W'(NUM_CH));
  assign beat_idx    = ch_offset[IDX_W-1:0];

  // Sample capture.
  // The display match is decided here, at beat time, so a later
  // display_channel change never retargets a sample already taken.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      sample_valid   <= 1'b0;
      sample_match   <= 1'b0;
      sample_channel <= '0;
      sample_data    <= '0;
    end else begin
      sample_valid <= beat_accept;
      sample_match <= beat_accept && (beat_idx == display_channel);
      if (beat_accept) begin
        sample_channel <= beat_idx;
        sample_data    <= response_data;
      end
    end
  end

  // Per-channel period counters.
  // A counter reloads to 1 on its own beat, so its value at the next beat
  // equals the cycle distance between the two beats.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_cnt[i] <= '0;
      end
      ch_seen       <= '0;
      period_valid  <= 1'b0;
      period_cycles <= '0;
    end else begin
      period_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (beat_accept && (beat_idx == IDX_W'(i))) begin
          period_cnt[i] <= PERIOD_W'(1);
          ch_seen[i]    <= 1'b1;
          if (ch_seen[i]) begin
            period_valid  <= 1'b1;
            period_cycles <= period_cnt[i];
          end
        end else if (period_cnt[i] != PERIOD_MAX) begin
          period_cnt[i] <= period_cnt[i] + PERIOD_W'(1);
        end
      end
    end
  end

  // A waiting pending request has priority over a fresh one, because it is
  // older. In that case the fresh one takes the slot the pending request
  // just vacated.
  assign conv_req      = sample_valid && sample_match;
  assign conv_start    = (state == IDLE) && (pend_full || conv_req);
  assign start_data    = pend_full ? pend_data : sample_data;
  assign start_ch      = pend_full ? pend_ch : sample_channel;
  assign start_product = PROD_W'(start_data) * PROD_W'(VREF_MV);
  assign step_last     = (step_cnt == LAST_STEP);

  // Restoring division step.
  // The remainder always stays below the divisor, so the subtraction can be
  // done modulo 2^DATA_W.
  assign div_trial    = {div_rem, div_q[MV_W-1]};
  assign div_ge       = (div_trial >= DIVISOR);
  assign div_rem_next = div_ge ? (div_trial[DATA_W-1:0] - DIVISOR[DATA_W-1:0])
                               : div_trial[DATA_W-1:0];

  // Converter state register.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Converter next state: IDLE -> DIV -> BCD -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (conv_start) state_next = DIV;
      DIV:  if (step_last)  state_next = BCD;
      BCD:  if (step_last)  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Converter datapath, pending slot and result registers.
  //
  // div_rem starts as the product's high part. div_q holds the low part and
  // collects quotient bits. During BCD the same register shifts the quotient
  // out, MSB first.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      div_rem     <= '0;
      div_q       <= '0;
      bcd_acc     <= '0;
      step_cnt    <= '0;
      conv_ch     <= '0;
      pend_full   <= 1'b0;
      pend_data   <= '0;
      pend_ch     <= '0;
      drop_count  <= '0;
      mv_bcd      <= '0;
      bcd_channel <= '0;
      bcd_valid   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (conv_start) begin
            div_rem  <= start_product[PROD_W-1:MV_W];
            div_q    <= start_product[MV_W-1:0];
            conv_ch  <= start_ch;
            step_cnt <= '0;
          end
        end
        DIV: begin
          div_rem  <= div_rem_next;
          div_q    <= {div_q[MV_W-2:0], div_ge};
          step_cnt <= step_last ? '0 : step_cnt + STEP_W'(1);
          if (step_last) begin
            bcd_acc <= '0;
          end
        end
        BCD: begin
          bcd_acc  <= dabble_step(bcd_acc, div_q[MV_W-1]);
          div_q    <= {div_q[MV_W-2:0], 1'b0};
          step_cnt <= step_cnt + STEP_W'(1);
        end
        DONE: begin
          mv_bcd      <= bcd_acc;
          bcd_channel <= conv_ch;
          bcd_valid   <= 1'b1;
        end
        default: ;
      endcase

      if (conv_start && pend_full) begin
        pend_full <= 1'b0;
      end
      if (conv_req && (busy || pend_full)) begin
        pend_full <= 1'b1;
        pend_data <= sample_data;
        pend_ch   <= sample_channel;
        if (busy && pend_full && (drop_count != 8'hFF)) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_channel_monitor.sv
`timescale 1ns/1ps
// tb_adc_channel_monitor
//
// Scoreboard bench for adc_channel_monitor.
//
// Structure:
//   - The stimulus side pushes expected pulses, with the cycle they are due,
//     into queues.
//   - A negedge monitor pops and compares whenever the DUT pulses.
//
// Reference model:
//   - Millivolts come from plain integer arithmetic.
//   - The converter is modelled as a time budget: a conversion started in
//     cycle s reports at s+2*MV_W+2, plus a one-deep pending slot.
module tb_adc_channel_monitor;

  localparam int DATA_W   = 12;
  localparam int NUM_CH   = 2;
  localparam int CH_BASE  = 1;
  localparam int CH_W     = 5;
  localparam int VREF_MV  = 5000;
  localparam int PERIOD_W = 16;
  localparam int DIGITS   = 4;
  localparam int MV_W     = $clog2(VREF_MV + 1);
  localparam int CONV_LAT = 2 * MV_W + 2;
  localparam int PMAX     = (1 << PERIOD_W) - 1;

  typedef struct {
    int cyc;
    int ch;
    int val;
  } exp_t;

  logic                MAX10_CLK1_50 = 1'b0;
  logic                reset = 1'b1;
  logic                response_valid = 1'b0;
  logic [CH_W-1:0]     response_channel = '0;
  logic [DATA_W-1:0]   response_data = '0;
  logic [0:0]          display_channel = '0;
  logic                sample_valid;
  logic [0:0]          sample_channel;
  logic [DATA_W-1:0]   sample_data;
  logic                period_valid;
  logic [PERIOD_W-1:0] period_cycles;
  logic [4*DIGITS-1:0] mv_bcd;
  logic [0:0]          bcd_channel;
  logic                bcd_valid;
  logic                busy;
  logic [7:0]          drop_count;

  adc_channel_monitor dut (
    .MAX10_CLK1_50   (MAX10_CLK1_50),
    .reset           (reset),
    .response_valid  (response_valid),
    .response_channel(response_channel),
    .response_data   (response_data),
    .display_channel (display_channel),
    .sample_valid    (sample_valid),
    .sample_channel  (sample_channel),
    .sample_data     (sample_data),
    .period_valid    (period_valid),
    .period_cycles   (period_cycles),
    .mv_bcd          (mv_bcd),
    .bcd_channel     (bcd_channel),
    .bcd_valid       (bcd_valid),
    .busy            (busy),
    .drop_count      (drop_count)
  );

  always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  int cyc = 0;
  always @(posedge MAX10_CLK1_50) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  exp_t sample_q[$];
  exp_t period_q[$];
  exp_t bcd_q[$];

  // Reference model state
  int  last_beat [NUM_CH];
  bit  seen [NUM_CH];
  int  idle_at = 0;
  bit  pend_full = 0;
  int  pend_ch = 0;
  int  pend_data = 0;
  int  drops = 0;
  int  last_bcd_exp = 0;
  int  ch_tab [7] = '{1, 2, 1, 2, 0, 3, 31};

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input int ch, input int v);
    exp_t e;
    e.cyc = c;
    e.ch  = ch;
    e.val = v;
    return e;
  endfunction

  function automatic int to_bcd(input int mv);
    int r = 0;
    int m = mv;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ((m % 10) << (4 * i));
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int mv_of(input int d);
    return (d * VREF_MV) / ((1 << DATA_W) - 1);
  endfunction

  task automatic startConv(input int s, input int ch, input int data);
    bcd_q.push_back(mk(s + CONV_LAT, ch, to_bcd(mv_of(data))));
    idle_at = s + CONV_LAT;
  endtask

  task automatic modelTick(input int now);
    if (pend_full && now >= idle_at) begin
      startConv(idle_at, pend_ch, pend_data);
      pend_full = 0;
    end
  endtask

  task automatic modelRequest(input int r, input int ch, input int data);
    modelTick(r);
    if (r >= idle_at) begin
      startConv(r, ch, data);
    end else begin
      if (pend_full && drops < 255) drops++;
      pend_full = 1;
      pend_ch   = ch;
      pend_data = data;
    end
  endtask

  task automatic modelClear();
    sample_q.delete();
    period_q.delete();
    bcd_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      seen[i] = 0;
      last_beat[i] = 0;
    end
    idle_at = 0;
    pend_full = 0;
    drops = 0;
    last_bcd_exp = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge MAX10_CLK1_50);
      #1;
      modelTick(cyc);
    end
  endtask

  // Drives one beat during the current cycle (called just after a rising edge)
  task automatic applyStimulus(input int ch, input int data, input int disp);
    int k;
    int li;
    k = cyc;
    response_valid   = 1'b1;
    response_channel = CH_W'(ch);
    response_data    = DATA_W'(data);
    display_channel  = 1'(disp);
    if (ch >= CH_BASE && ch < CH_BASE + NUM_CH) begin
      li = ch - CH_BASE;
      sample_q.push_back(mk(k + 1, li, data));
      if (seen[li]) begin
        period_q.push_back(mk(k + 1, li, (k - last_beat[li] > PMAX) ? PMAX : k - last_beat[li]));
      end
      seen[li] = 1;
      last_beat[li] = k;
      if (li == disp) modelRequest(k + 1, li, data);
    end
    @(posedge MAX10_CLK1_50);
    #1;
    response_valid = 1'b0;
    modelTick(cyc);
  endtask

  task automatic checkResetState();
    checkOutput("reset sample_valid", sample_valid, 0);
    checkOutput("reset sample_channel", sample_channel, 0);
    checkOutput("reset sample_data", sample_data, 0);
    checkOutput("reset period_valid", period_valid, 0);
    checkOutput("reset period_cycles", period_cycles, 0);
    checkOutput("reset mv_bcd", mv_bcd, 0);
    checkOutput("reset bcd_channel", bcd_channel, 0);
    checkOutput("reset bcd_valid", bcd_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset drop_count", drop_count, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelClear();
    @(posedge MAX10_CLK1_50);
    #1;
    checkResetState();
    @(posedge MAX10_CLK1_50);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops the oldest expectation whenever the DUT pulses
  always @(negedge MAX10_CLK1_50) begin
    exp_t e;
    if (sample_valid) begin
      if (sample_q.size() == 0) begin
        checkOutput("unexpected sample_valid", 1, 0);
      end else begin
        e = sample_q.pop_front();
        checkOutput("sample_valid cycle", cyc, e.cyc);
        checkOutput("sample_channel", sample_channel, e.ch);
        checkOutput("sample_data", sample_data, e.val);
      end
    end
    if (period_valid) begin
      if (period_q.size() == 0) begin
        checkOutput("unexpected period_valid", 1, 0);
      end else begin
        e = period_q.pop_front();
        checkOutput("period_valid cycle", cyc, e.cyc);
        checkOutput("period channel", sample_channel, e.ch);
        checkOutput("period_cycles", period_cycles, e.val);
      end
    end
    if (bcd_valid) begin
      if (bcd_q.size() == 0) begin
        checkOutput("unexpected bcd_valid", 1, 0);
      end else begin
        e = bcd_q.pop_front();
        last_bcd_exp = e.val;
        checkOutput("bcd_valid cycle", cyc, e.cyc);
        checkOutput("bcd_channel", bcd_channel, e.ch);
        checkOutput("mv_bcd", mv_bcd, e.val);
      end
    end
  end

  initial begin
    int data_tab [4] = '{4095, 2048, 1, 0};
    int pick;

    // Power-on reset
    repeat (3) @(posedge MAX10_CLK1_50);
    #1;
    checkResetState();
    modelClear();
    reset = 1'b0;
    idleCycles(2);

    // Single conversions, including the floor-rounding corner cases
    foreach (data_tab[i]) begin
      applyStimulus(1, data_tab[i], 0);
      idleCycles(CONV_LAT + 6);
      checkOutput("mv_bcd hold", mv_bcd, last_bcd_exp);
    end
    checkOutput("mv_bcd 0 data", mv_bcd, 16'h0000);

    // Channel-1 beats every 50 cycles, with ignored channels in between
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1, 100 * b + 7, 1);
      idleCycles(10);
      applyStimulus(0, 111, 1);
      idleCycles(10);
      applyStimulus(3, 222, 1);
      idleCycles(10);
      applyStimulus(31, 333, 1);
      idleCycles(16);
    end
    idleCycles(4);
    checkOutput("period_cycles hold", period_cycles, 50);

    // Saturating period on channel 2 (local index 1)
    applyStimulus(2, 10, 0);
    idleCycles(69999);
    applyStimulus(2, 20, 0);
    idleCycles(40);
    checkOutput("period_cycles saturated", period_cycles, PMAX);

    // Three matching beats 5 cycles apart: middle one is dropped
    applyStimulus(1, 4095, 0);
    idleCycles(4);
    applyStimulus(1, 2048, 0);
    idleCycles(4);
    applyStimulus(1, 1000, 0);
    idleCycles(2 * CONV_LAT + 10);
    checkOutput("drop_count after overwrite", drop_count, 1);
    checkOutput("mv_bcd after pending", mv_bcd, to_bcd(mv_of(1000)));

    // Randomized beats, gaps short enough to exercise pending and drops
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 6);
      applyStimulus(ch_tab[pick], $urandom_range(0, 4095), $urandom_range(0, 1));
      idleCycles($urandom_range(0, 60));
    end
    idleCycles(2 * CONV_LAT + 10);
    checkOutput("drop_count random", drop_count, drops);
    checkOutput("busy after drain", busy, 0);
    checkOutput("mv_bcd hold random", mv_bcd, last_bcd_exp);

    // Reset in the middle of a conversion, then a normal conversion
    applyStimulus(1, 3000, 0);
    idleCycles(9);
    doReset();
    idleCycles(CONV_LAT + 10);
    checkOutput("mv_bcd after abort", mv_bcd, 0);
    applyStimulus(1, 3000, 0);
    idleCycles(CONV_LAT + 6);
    checkOutput("mv_bcd after reset", mv_bcd, to_bcd(mv_of(3000)));

    // Nothing expected may be left outstanding
    checkOutput("missing sample pulses", sample_q.size(), 0);
    checkOutput("missing period pulses", period_q.size(), 0);
    checkOutput("missing bcd pulses", bcd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
